seq_sub128: RTL and testbench

- Multi-cycle 128-bit subtractor: computes D = A - B - bin as four 32-bit beats.
- Each beat uses an add-one carry-select slice on A + ~B, with the carry chained between beats.
- Provides the inverse arithmetic direction to the team's hierarchical carry-select adders, for area-constrained paths.
- Valid/ready on both sides. Also exports 128-bit group generate/propagate so it can feed a higher-level lookahead.

---
 rtl/seq_arith_pkg.sv | 15 +
 rtl/seq_sub128_slice.sv | 27 ++
 rtl/seq_sub128.sv | 139 +++++++++++++
 tb/tb_seq_sub128.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared constants and FSM encoding for the sequential subtractor.
package seq_arith_pkg;

  localparam int N      = 128;
  localparam int W      = 32;
  localparam int SLICES = N / W;
  localparam int CW     = $clog2(SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_sub128_slice.sv
// W-bit add-one carry-select slice: precomputes a+b and a+b+1, the incoming
// carry picks one. gen/prop describe a+b alone, so they exclude cin.
module a1cs_slice32
  import seq_arith_pkg::*;
(
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         gen,
  output logic         prop,
  output logic         cout
);

  logic [W:0] sum0;
  logic [W:0] sum1;

  // sum1 cannot overflow W+1 bits: sum0 is at most 2^(W+1)-2.
  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = sum0 + (W+1)'(1);

  assign s    = cin ? sum1[W-1:0] : sum0[W-1:0];
  assign cout = cin ? sum1[W]     : sum0[W];
  assign gen  = sum0[W];
  assign prop = &(a ^ b);

endmodule

// File: rtl/seq_sub128.sv
// Multi-cycle 128-bit subtractor D = A - B - bin, one 32-bit beat per cycle
// through a single time-multiplexed carry-select slice.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | one slice per cycle, counter selects the beat
// DONE  | result held with out_valid until out_ready
module seq_sub128
  import seq_arith_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         gen,
  output logic         prop,
  output logic         zero
);

  state_t        state_q, state_n;
  logic [N-1:0]  a_q, nb_q, d_q, d_nxt;
  logic [CW-1:0] cnt_q;
  logic          carry_q, g_acc, p_acc;
  logic          bout_q, gen_q, prop_q, zero_q;
  logic          accept, last;

  logic [W-1:0]  s_k;
  logic          g_k, p_k, c_k, g_nxt, p_nxt;

  a1cs_slice32 u_slice (
    .cin  (carry_q),
    .a    (a_q[W*cnt_q +: W]),
    .b    (nb_q[W*cnt_q +: W]),
    .s    (s_k),
    .gen  (g_k),
    .prop (p_k),
    .cout (c_k)
  );

  assign last = (cnt_q == CW'(SLICES-1));

  // Group G/P fold; beat 0 seeds the accumulators directly.
  always_comb begin
    g_nxt = g_k;
    p_nxt = p_k;
    if (cnt_q != '0) begin
      g_nxt = g_k | (p_k & g_acc);
      p_nxt = p_acc & p_k;
    end
  end

  // Result vector with the current beat merged in.
  always_comb begin
    d_nxt = d_q;
    d_nxt[W*cnt_q +: W] = s_k;
  end

  // Next-state and operand-accept decode.
  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            accept  = 1'b1;
            state_n = BUSY;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, operand latch, per-beat accumulation and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      g_acc   <= 1'b0;
      p_acc   <= 1'b0;
      bout_q  <= 1'b0;
      gen_q   <= 1'b0;
      prop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        a_q     <= a;
        nb_q    <= ~b;
        carry_q <= ~bin;
        cnt_q   <= '0;
      end else if (state_q == BUSY) begin
        d_q     <= d_nxt;
        carry_q <= c_k;
        g_acc   <= g_nxt;
        p_acc   <= p_nxt;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          bout_q <= ~c_k;
          gen_q  <= g_nxt;
          prop_q <= p_nxt;
          zero_q <= (d_nxt == '0);
        end
      end
    end
  end

  assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;
  assign gen       = gen_q;
  assign prop      = prop_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_sub128.sv
// Directed scoreboard bench for seq_sub128.
module tb_seq_sub128;
  import seq_arith_pkg::*;

  typedef struct packed {
    logic [N-1:0] d;
    logic         bout;
    logic         gen;
    logic         prop;
    logic         zero;
  } exp_t;

  logic         clk, rst;
  logic         in_valid, in_ready, bin;
  logic [N-1:0] a, b, d;
  logic         out_valid, out_ready;
  logic         bout, gen, prop, zero;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_sub128 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .gen       (gen),
    .prop      (prop),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic, no slicing.
  function automatic exp_t model(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic bi);
    exp_t       e;
    logic [N:0] s0;
    e.d    = aa - bb - N'(bi);
    e.bout = ({1'b0, aa} < ({1'b0, bb} + (N+1)'(bi)));
    s0     = {1'b0, aa} + {1'b0, ~bb};
    e.gen  = s0[N];
    e.prop = &(aa ^ ~bb);
    e.zero = (e.d == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic bi, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", N'(in_ready), N'(1));
    in_valid = 1'b1;
    a = aa;
    b = bb;
    bin = bi;
    if (push) sb.push_back(model(aa, bb, bi));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a   = {$urandom, $urandom, $urandom, $urandom};
    b   = {$urandom, $urandom, $urandom, $urandom};
    bin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input bit chk_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    chk("out_valid_seen", N'(out_valid), N'(1));
    if (chk_lat) chk("latency_edges", N'(n - 1), N'(SLICES));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard_empty observed=result expected=none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_d"},    d,       e.d);
      chk({tag, "_bout"}, N'(bout), N'(e.bout));
      chk({tag, "_gen"},  N'(gen),  N'(e.gen));
      chk({tag, "_prop"}, N'(prop), N'(e.prop));
      chk({tag, "_zero"}, N'(zero), N'(e.zero));
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", N'(out_valid), N'(0));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] aa, input logic [N-1:0] bb, input logic bi);
    send(aa, bb, bi, 1'b1);
    wait_valid(1'b1);
    pop_check(tag);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] hold;
    logic [N-1:0] pat;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    #2;
    chk("rst_in_ready",  N'(in_ready),  N'(0));
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_d",         d,             '0);
    chk("rst_flags",     N'({bout, gen, prop, zero}), N'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", N'(in_ready), N'(1));

    run_op("sub_5_3", N'(5), N'(3), 1'b0);
    run_op("sub_0_1", N'(0), N'(1), 1'b0);
    pat = {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
    run_op("eq_bin1", pat, pat, 1'b1);
    run_op("eq_bin0", pat, pat, 1'b0);
    run_op("zero_zero", N'(0), N'(0), 1'b0);
    run_op("ripple_2p96", N'(1) << 96, N'(1), 1'b0);
    run_op("wrap_bin", N'(3), N'(3) << 100, 1'b1);

    // Backpressure: result must hold while out_ready stays low.
    send(N'(10), N'(3), 1'b0, 1'b1);
    wait_valid(1'b1);
    hold = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_d_stable",  d,              hold);
      chk("bp_in_ready",  N'(in_ready),   N'(0));
      chk("bp_out_valid", N'(out_valid),  N'(1));
    end
    pop_check("bp_result");

    // Release and offer the next operands on the same edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = N'(7);
    b = N'(2);
    bin = 1'b0;
    sb.push_back(model(N'(7), N'(2), 1'b0));
    #1;
    chk("b2b_in_ready", N'(in_ready), N'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    a = '1;
    b = '1;
    chk("b2b_out_valid_drop", N'(out_valid), N'(0));
    wait_valid(1'b1);
    chk("b2b_d_is_5", d, N'(5));
    pop_check("b2b_result");
    handshake();

    // Reset in the middle of an operation discards the partial result.
    send(N'(9), N'(4), 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_partial_nonzero", N'(d != '0), N'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", N'(out_valid), N'(0));
    chk("mid_rst_d",         d,             '0);
    chk("mid_rst_in_ready",  N'(in_ready),  N'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst_1_1", N'(1), N'(1), 1'b0);

    chk("sb_drained", N'(sb.size()), N'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
